// File: rtl/debounce_n_pkg.sv
// Shared definitions for the multi-channel push-button conditioner.
package debounce_n_pkg;

    typedef enum logic [1:0] {
        STABLE_0 = 2'd0,
        WAIT_1   = 2'd1,
        STABLE_1 = 2'd2,
        WAIT_0   = 2'd3
    } db_state_e;

    // One spare bit above the largest count so the counter never wraps.
    function automatic int unsigned cnt_width(
        input int unsigned delay,
        input int unsigned rep_first,
        input int unsigned rep_rate
    );
        int unsigned m;
        m = delay;
        if (rep_first > m) m = rep_first;
        if (rep_rate > m) m = rep_rate;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced channel: two-flop synchroniser, settle/repeat counter and event FSM.
module debounce_ch
    import debounce_n_pkg::*;
#(
    parameter int unsigned DELAY        = 32768,
    parameter int unsigned REPEAT_FIRST = 0,
    parameter int unsigned REPEAT_RATE  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_out,
    output logic press,
    output logic release_pulse
);

    localparam int unsigned CW = cnt_width(DELAY, REPEAT_FIRST, REPEAT_RATE);
    localparam logic [CW-1:0] DLY_LAST = CW'(DELAY - 32'd1);
    localparam logic [CW-1:0] RF_LAST  = CW'((REPEAT_FIRST != 0) ? REPEAT_FIRST - 32'd1 : 32'd0);
    localparam logic [CW-1:0] RR_LAST  = CW'((REPEAT_RATE != 0) ? REPEAT_RATE - 32'd1 : 32'd0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam bit REP_EN  = (REPEAT_FIRST != 0);
    localparam bit RATE_EN = (REPEAT_RATE != 0);

    logic          sync_q;
    logic          s_q;
    db_state_e     state;
    logic [CW-1:0] cnt;
    logic          rep;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q        <= 1'b0;
            s_q           <= 1'b0;
            state         <= STABLE_0;
            cnt           <= '0;
            rep           <= 1'b0;
            sw_out        <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q        <= sw_in;
            s_q           <= sync_q;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                STABLE_0: begin
                    if (s_q) begin
                        state  <= WAIT_1;
                        cnt    <= '0;
                        press  <= 1'b1;
                        sw_out <= 1'b1;
                    end
                end
                WAIT_1: begin
                    if (cnt == DLY_LAST) begin
                        state <= STABLE_1;
                        cnt   <= '0;
                        rep   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE_1: begin
                    // Release wins over a repeat that would fire on the same edge.
                    if (!s_q) begin
                        state         <= WAIT_0;
                        cnt           <= '0;
                        rep           <= 1'b0;
                        release_pulse <= 1'b1;
                        sw_out        <= 1'b0;
                    end else if (REP_EN) begin
                        if (!rep) begin
                            if (cnt == RF_LAST) begin
                                press <= 1'b1;
                                cnt   <= '0;
                                rep   <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (RATE_EN) begin
                            if (cnt == RR_LAST) begin
                                press <= 1'b1;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                WAIT_0: begin
                    if (cnt == DLY_LAST) begin
                        state <= STABLE_0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE_0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/debounce_n.sv
// NCH independent debounced push-button channels with press/release events and optional auto-repeat.
module debounce_n
    import debounce_n_pkg::*;
#(
    parameter int unsigned NCH          = 2,
    parameter int unsigned DELAY        = 32768,
    parameter int unsigned REPEAT_FIRST = 0,
    parameter int unsigned REPEAT_RATE  = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] sw_in,
    output logic [NCH-1:0] sw_out,
    output logic [NCH-1:0] press,
    output logic [NCH-1:0] release_pulse
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        debounce_ch #(
            .DELAY        (DELAY),
            .REPEAT_FIRST (REPEAT_FIRST),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .sw_in         (sw_in[g]),
            .sw_out        (sw_out[g]),
            .press         (press[g]),
            .release_pulse (release_pulse[g])
        );
    end

endmodule

// File: tb/tb_debounce_n.sv
// Bench for debounce_n: three parameterisations driven in parallel against a deadline-based reference model.
module tb_debounce_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;

    logic [1:0] a_out, a_pr, a_rl;
    logic [1:0] b_out, b_pr, b_rl;
    logic [1:0] c_out, c_pr, c_rl;

    always #5 clk = ~clk;

    debounce_n #(.NCH(2), .DELAY(4), .REPEAT_FIRST(0), .REPEAT_RATE(0)) u_a (
        .clk(clk), .rst(rst), .sw_in(sw), .sw_out(a_out), .press(a_pr), .release_pulse(a_rl));
    debounce_n #(.NCH(2), .DELAY(4), .REPEAT_FIRST(10), .REPEAT_RATE(4)) u_b (
        .clk(clk), .rst(rst), .sw_in(sw), .sw_out(b_out), .press(b_pr), .release_pulse(b_rl));
    debounce_n #(.NCH(2), .DELAY(2), .REPEAT_FIRST(3), .REPEAT_RATE(0)) u_c (
        .clk(clk), .rst(rst), .sw_in(sw), .sw_out(c_out), .press(c_pr), .release_pulse(c_rl));

    // Reference model: per-channel debounced level plus absolute-cycle deadlines.
    int unsigned cfg_d  [3] = '{4, 4, 2};
    int unsigned cfg_rf [3] = '{0, 10, 3};
    int unsigned cfg_rr [3] = '{0, 4, 0};
    bit          lvl  [3][2];
    int unsigned busy [3][2];
    int unsigned nrep [3][2];
    bit          ep   [3][2];
    bit          er   [3][2];
    bit          p1 [2];
    bit          p2 [2];
    int unsigned cyc;
    int          checks;
    int          passed;

    function automatic logic [17:0] act_vec();
        return {c_rl, c_pr, c_out, b_rl, b_pr, b_out, a_rl, a_pr, a_out};
    endfunction

    function automatic logic [17:0] exp_vec();
        logic [17:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                v[i*6 + ch]     = lvl[i][ch];
                v[i*6 + 2 + ch] = ep[i][ch];
                v[i*6 + 4 + ch] = er[i][ch];
            end
        end
        return v;
    endfunction

    // Advance one clock and update the model with what the DUT sampled at that edge.
    task automatic tick();
        bit x;
        @(posedge clk);
        #1;
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            x = p2[ch];
            for (int i = 0; i < 3; i++) begin
                ep[i][ch] = 1'b0;
                er[i][ch] = 1'b0;
                if (!rst) begin
                    lvl[i][ch]  = 1'b0;
                    busy[i][ch] = 0;
                    nrep[i][ch] = 0;
                end else if (cyc > busy[i][ch]) begin
                    if (!lvl[i][ch] && x) begin
                        lvl[i][ch]  = 1'b1;
                        ep[i][ch]   = 1'b1;
                        busy[i][ch] = cyc + cfg_d[i];
                        nrep[i][ch] = (cfg_rf[i] != 0) ? cyc + cfg_d[i] + cfg_rf[i] : 0;
                    end else if (lvl[i][ch] && !x) begin
                        lvl[i][ch]  = 1'b0;
                        er[i][ch]   = 1'b1;
                        busy[i][ch] = cyc + cfg_d[i];
                        nrep[i][ch] = 0;
                    end else if (lvl[i][ch] && nrep[i][ch] != 0 && cyc == nrep[i][ch]) begin
                        ep[i][ch]   = 1'b1;
                        nrep[i][ch] = (cfg_rr[i] != 0) ? cyc + cfg_rr[i] : 0;
                    end
                end
            end
            if (!rst) begin
                p1[ch] = 1'b0;
                p2[ch] = 1'b0;
            end else begin
                p2[ch] = p1[ch];
                p1[ch] = sw[ch];
            end
        end
    endtask

    task automatic settle(input int n);
        sw  = 2'b00;
        rst = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sw  = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (act_vec() !== 18'h0) $display("FAIL reset cyc=%0d got=%h want=%h", cyc, act_vec(), 18'h0);
            else passed++;
        end
    endtask

    task automatic test_single_press();
        int unsigned t0;
        int npress;
        settle(16);
        t0 = cyc;
        sw[0] = 1'b1;
        npress = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            npress += int'(a_pr[0]);
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL single_press cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            else passed++;
            if (cyc == t0 + 3) begin
                checks++;
                if ({a_out[0], a_pr[0]} !== 2'b11) $display("FAIL press_latency got=%b want=11", {a_out[0], a_pr[0]});
                else passed++;
            end
        end
        checks++;
        if (npress !== 1) $display("FAIL single_press_count got=%0d want=1", npress);
        else passed++;
    endtask

    task automatic test_bounce();
        int unsigned t0;
        int npress, nrel;
        settle(16);
        t0 = cyc;
        npress = 0;
        nrel = 0;
        for (int k = 0; k < 18; k++) begin
            sw[0] = (k < 4) ? ~k[0] : 1'b0;
            tick();
            npress += int'(a_pr[0]);
            nrel   += int'(a_rl[0]);
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL bounce cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if ({npress, nrel} !== {32'd1, 32'd1}) $display("FAIL bounce_count got=%0d/%0d want=1/1", npress, nrel);
        else passed++;
    endtask

    task automatic test_release_lockout();
        int unsigned t1;
        int early;
        settle(16);
        sw[0] = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        t1 = cyc;
        sw[0] = 1'b0;
        early = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (cyc == t1 + 2) sw[0] = 1'b1;
            if (cyc > t1 + 3 && cyc < t1 + 8) early += int'(a_pr[0]);
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL lockout cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            else passed++;
            if (cyc == t1 + 3 || cyc == t1 + 8) begin
                checks++;
                if ({a_pr[0], a_rl[0]} !== ((cyc == t1 + 3) ? 2'b01 : 2'b10))
                    $display("FAIL lockout_edge cyc=%0d got=%b", cyc, {a_pr[0], a_rl[0]});
                else passed++;
            end
        end
        checks++;
        if (early !== 0) $display("FAIL lockout_early got=%0d want=0", early);
        else passed++;
    endtask

    task automatic test_repeat();
        int na, nb, nc;
        settle(16);
        sw[0] = 1'b1;
        na = 0; nb = 0; nc = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            na += int'(a_pr[0]);
            nb += int'(b_pr[0]);
            nc += int'(c_pr[0]);
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL repeat cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if ({na, nb, nc} !== {32'd1, 32'd7, 32'd2}) $display("FAIL repeat_count got=%0d/%0d/%0d want=1/7/2", na, nb, nc);
        else passed++;
        sw[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL repeat_release cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            else passed++;
        end
    endtask

    task automatic test_two_channels();
        int unsigned t0;
        settle(16);
        t0 = cyc;
        sw = 2'b11;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (cyc == t0 + 5) sw[1] = 1'b0;
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL two_ch cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            else passed++;
            if (cyc == t0 + 3) begin
                checks++;
                if (a_pr !== 2'b11) $display("FAIL two_ch_press got=%b want=11", a_pr);
                else passed++;
            end
        end
        checks++;
        if (a_out !== 2'b01) $display("FAIL two_ch_level got=%b want=01", a_out);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int unsigned r;
        settle(16);
        sw[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b0;
        tick();
        r = cyc;
        checks++;
        if (act_vec() !== 18'h0) $display("FAIL mid_reset got=%h want=%h", act_vec(), 18'h0);
        else passed++;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            else passed++;
            if (cyc == r + 3) begin
                checks++;
                if (a_pr[0] !== 1'b1) $display("FAIL post_reset_press got=%b want=1", a_pr[0]);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        settle(16);
        for (int k = 0; k < 1500; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(5) == 0) sw[ch] = ~sw[ch];
            end
            rst = ($urandom_range(299) != 0);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) $display("FAIL random cyc=%0d got=%h want=%h", cyc, act_vec(), exp_vec());
            else passed++;
        end
    endtask

    initial begin
        rst    = 1'b0;
        sw     = 2'b00;
        cyc    = 0;
        checks = 0;
        passed = 0;
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                lvl[i][ch]  = 1'b0;
                busy[i][ch] = 0;
                nrep[i][ch] = 0;
                ep[i][ch]   = 1'b0;
                er[i][ch]   = 1'b0;
            end
        end
        p1 = '{1'b0, 1'b0};
        p2 = '{1'b0, 1'b0};
        test_reset();
        test_single_press();
        test_bounce();
        test_release_lockout();
        test_repeat();
        test_two_channels();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
